// File: rtl/i2c_frame_receiver.sv
// I2C-style write-only slave receiver with multi-byte frames.
// Recovers SCL/SDA events from oversampled pins, filters by 7-bit address, ACKs each accepted
// byte open-drain and presents a complete frame as one parallel word.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   scl, sda_in     bus pin levels (asynchronous to clk)
//   sda_oe          1 = pull SDA low (ACK)
//   frame_data      payload, first received byte in [7:0]
//   frame_valid     one-cycle strobe, frame_data/pr/rate updated in the same cycle
//   frame_err       one-cycle strobe on an aborted or malformed frame
//   busy            FSM not idle
//   pr, rate        byte 0 [3:0] and [6:4] of the last good frame
module i2c_frame_receiver #(
    parameter int unsigned DATA_BYTES     = 2,
    parameter logic [6:0]  SLAVE_ADDR     = 7'h2A,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scl,
    input  logic                      sda_in,
    output logic                      sda_oe,
    output logic [8*DATA_BYTES-1:0]   frame_data,
    output logic                      frame_valid,
    output logic                      frame_err,
    output logic                      busy,
    output logic [3:0]                pr,
    output logic [2:0]                rate
);

    localparam int unsigned BW = $clog2(DATA_BYTES + 2);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] NumBytes   = BW'(DATA_BYTES);
    localparam logic [BW-1:0] MaxByteCnt = BW'(DATA_BYTES + 1);
    localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {StIdle, StAddr, StAddrAck, StData, StDataAck, StWaitStop} state_e;

    // Synchronisers reset to the idle bus level so reset release creates no false edges.
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_dly_q, sda_dly_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
            sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_dly_q;
    assign scl_fall  = ~scl_s & scl_dly_q;
    assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

    state_e                  state_q, state_d;
    logic [7:0]              shreg_q, shreg_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]           byte_cnt_q, byte_cnt_d;
    logic                    half_q, half_d;
    logic [8*DATA_BYTES-1:0] buf_q, buf_d, frame_data_q, frame_data_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                    sda_oe_q, sda_oe_d, valid_q, valid_d, err_q, err_d;
    logic [3:0]              pr_q, pr_d;
    logic [2:0]              rate_q, rate_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            half_q       <= 1'b0;
            buf_q        <= '0;
            frame_data_q <= '0;
            tmo_cnt_q    <= '0;
            sda_oe_q     <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            pr_q         <= '0;
            rate_q       <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            half_q       <= half_d;
            buf_q        <= buf_d;
            frame_data_q <= frame_data_d;
            tmo_cnt_q    <= tmo_cnt_d;
            sda_oe_q     <= sda_oe_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            pr_q         <= pr_d;
            rate_q       <= rate_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        half_d       = half_q;
        buf_d        = buf_q;
        frame_data_d = frame_data_q;
        sda_oe_d     = sda_oe_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        pr_d         = pr_q;
        rate_d       = rate_q;

        if (state_q == StIdle || scl_rise || scl_fall) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TimeoutVal) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end

        // Bits are shifted on the rising edge but counted on the following falling edge, so
        // the SCL rise that precedes a STOP leaves bit_cnt at 0 and the fall that ends a START
        // (no preceding rise) is not counted.
        if ((state_q == StAddr || state_q == StData) && scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_s};
            half_d  = 1'b1;
        end

        if (start_det) begin
            if (state_q inside {StAddrAck, StData, StDataAck}) err_d = 1'b1;
            state_d    = StAddr;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            half_d     = 1'b0;
            sda_oe_d   = 1'b0;
        end else if (stop_det) begin
            if (state_q == StData || state_q == StDataAck) begin
                if (byte_cnt_q == NumBytes && bit_cnt_q == 4'd0) begin
                    valid_d      = 1'b1;
                    frame_data_d = buf_q;
                    pr_d         = buf_q[3:0];
                    rate_d       = buf_q[6:4];
                end else begin
                    err_d = 1'b1;
                end
            end
            state_d  = StIdle;
            sda_oe_d = 1'b0;
        end else if (scl_fall) begin
            half_d = 1'b0;
            case (state_q)
                StAddr: begin
                    if (half_q) begin
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd8;
                            if (shreg_q == {SLAVE_ADDR, 1'b0}) begin
                                sda_oe_d = 1'b1;
                                state_d  = StAddrAck;
                            end else begin
                                state_d = StWaitStop;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StData: begin
                    if (half_q) begin
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd8;
                            for (int i = 0; i < int'(DATA_BYTES); i++) begin
                                if (byte_cnt_q == BW'(i)) buf_d[8*i +: 8] = shreg_q;
                            end
                            sda_oe_d = (byte_cnt_q < NumBytes);
                            if (byte_cnt_q != MaxByteCnt) byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d = StDataAck;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                // Falling edge that ends the 9th clock.
                StAddrAck, StDataAck: begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
                default: ;
            endcase
        end else if (!scl_rise && state_q != StIdle && tmo_cnt_q == TimeoutVal) begin
            err_d    = 1'b1;
            sda_oe_d = 1'b0;
            half_d   = 1'b0;
            state_d  = StIdle;
        end
    end

    assign sda_oe      = sda_oe_q;
    assign frame_data  = frame_data_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != StIdle);
    assign pr          = pr_q;
    assign rate        = rate_q;

endmodule
